// File: rtl/vx_bits_extract_buf.sv
// Stream stage that strips an S-bit sideband field spliced in at bit POS and
// registers payload and field separately behind a 2-entry skid buffer.
module vx_bits_extract_buf #(
    parameter int N   = 1,
    parameter int S   = 1,
    parameter int POS = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    input  logic [N+S-1:0]                 data_in,
    output logic                           ready_in,
    input  logic                           ready_out,
    output logic                           valid_out,
    output logic [N-1:0]                   data_out,
    output logic [((S > 0) ? S : 1)-1:0]   ext_out
);

    localparam int SP = (S > 0) ? S : 1;

    // Buffer occupancy encoded as {mainValid, skidValid}.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] FULL  = 2'b11;

    logic [N-1:0]  splitData;
    logic [SP-1:0] splitExt;

    logic [N-1:0]  mainData_q, mainData_d;
    logic [SP-1:0] mainExt_q,  mainExt_d;
    logic          mainValid_q, mainValid_d;
    logic [N-1:0]  skidData_q, skidData_d;
    logic [SP-1:0] skidExt_q,  skidExt_d;
    logic          skidValid_q, skidValid_d;

    logic inFire;
    logic outFire;

    generate
        if (S == 0) begin : g_pass
            assign splitData = data_in;
            assign splitExt  = '0;
        end else if (POS == 0) begin : g_low
            assign splitData = data_in[N+S-1:S];
            assign splitExt  = data_in[S-1:0];
        end else if (POS == N) begin : g_high
            assign splitData = data_in[N-1:0];
            assign splitExt  = data_in[N+S-1:N];
        end else begin : g_mid
            assign splitData = {data_in[N+S-1:POS+S], data_in[POS-1:0]};
            assign splitExt  = data_in[POS+S-1:POS];
        end
    endgenerate

    // ready_in comes straight from a flop, so ready_out never reaches it combinationally.
    assign ready_in  = !skidValid_q;
    assign valid_out = mainValid_q;
    assign data_out  = mainData_q;
    assign ext_out   = mainExt_q;

    assign inFire  = valid_in && ready_in;
    assign outFire = mainValid_q && ready_out;

    always_comb begin
        mainData_d  = mainData_q;
        mainExt_d   = mainExt_q;
        mainValid_d = mainValid_q;
        skidData_d  = skidData_q;
        skidExt_d   = skidExt_q;
        skidValid_d = skidValid_q;

        case ({mainValid_q, skidValid_q})
            EMPTY: begin
                if (inFire) begin
                    mainData_d  = splitData;
                    mainExt_d   = splitExt;
                    mainValid_d = 1'b1;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    mainData_d = splitData;
                    mainExt_d  = splitExt;
                end else if (inFire) begin
                    skidData_d  = splitData;
                    skidExt_d   = splitExt;
                    skidValid_d = 1'b1;
                end else if (outFire) begin
                    mainValid_d = 1'b0;
                end
            end
            FULL: begin
                if (outFire) begin
                    mainData_d  = skidData_q;
                    mainExt_d   = skidExt_q;
                    skidValid_d = 1'b0;
                end
            end
            default: begin
                // Skid-only is unreachable; fall back to empty if it ever appears.
                mainValid_d = 1'b0;
                skidValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mainData_q  <= '0;
            mainExt_q   <= '0;
            mainValid_q <= 1'b0;
            skidData_q  <= '0;
            skidExt_q   <= '0;
            skidValid_q <= 1'b0;
        end else begin
            mainData_q  <= mainData_d;
            mainExt_q   <= mainExt_d;
            mainValid_q <= mainValid_d;
            skidData_q  <= skidData_d;
            skidExt_q   <= skidExt_d;
            skidValid_q <= skidValid_d;
        end
    end

endmodule

// File: tb/tb_vx_bits_extract_buf.sv
// Bench for vx_bits_extract_buf: POS=3 stream DUT against a scoreboard, plus
// POS=0, POS=N and S=0 builds checked with single words.
module tb_vx_bits_extract_buf;

    logic       clk = 1'b0;
    logic       reset;

    logic       validIn, readyIn, readyOut, validOut;
    logic [9:0] dataIn;
    logic [7:0] dataOut;
    logic [1:0] extOut;

    logic       validIn2, readyOut2;
    logic [9:0] dataIn2;
    logic       readyIn0, validOut0, readyIn8, validOut8;
    logic [7:0] dataOut0, dataOut8;
    logic [1:0] extOut0, extOut8;

    logic       validInS, readyInS, validOutS;
    logic [7:0] dataInS, dataOutS;
    logic [0:0] extOutS;

    int checks = 0;
    int errors = 0;

    logic [9:0] scoreQ[$];
    logic [9:0] curExp;
    int         occ = 0;
    int         outCount = 0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData;
    logic [1:0] prevExt;
    logic       randDone;

    always #5 clk = ~clk;

    vx_bits_extract_buf #(.N(8), .S(2), .POS(3)) dut (
        .clk(clk), .reset(reset), .valid_in(validIn), .data_in(dataIn),
        .ready_in(readyIn), .ready_out(readyOut), .valid_out(validOut),
        .data_out(dataOut), .ext_out(extOut)
    );

    vx_bits_extract_buf #(.N(8), .S(2), .POS(0)) dutP0 (
        .clk(clk), .reset(reset), .valid_in(validIn2), .data_in(dataIn2),
        .ready_in(readyIn0), .ready_out(readyOut2), .valid_out(validOut0),
        .data_out(dataOut0), .ext_out(extOut0)
    );

    vx_bits_extract_buf #(.N(8), .S(2), .POS(8)) dutP8 (
        .clk(clk), .reset(reset), .valid_in(validIn2), .data_in(dataIn2),
        .ready_in(readyIn8), .ready_out(readyOut2), .valid_out(validOut8),
        .data_out(dataOut8), .ext_out(extOut8)
    );

    vx_bits_extract_buf #(.N(8), .S(0), .POS(0)) dutS0 (
        .clk(clk), .reset(reset), .valid_in(validInS), .data_in(dataInS),
        .ready_in(readyInS), .ready_out(readyOut2), .valid_out(validOutS),
        .data_out(dataOutS), .ext_out(extOutS)
    );

    // Builds the wire word the way the inserting side would for POS=3.
    function automatic logic [9:0] ins3(input logic [7:0] p, input logic [1:0] f);
        return {p[7:3], f, p[2:0]};
    endfunction

    // Negedge monitor: occupancy model, stall stability and the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            scoreQ.delete();
            occ = 0;
            prevStall = 1'b0;
        end else begin
            checks++;
            if (readyIn !== (occ < 2)) begin
                errors++;
                $display("[TB] FAIL ready_in_occ occ=%0d got=%b want=%b", occ, readyIn, (occ < 2));
            end
            checks++;
            if (validOut !== (occ > 0)) begin
                errors++;
                $display("[TB] FAIL valid_out_occ occ=%0d got=%b want=%b", occ, validOut, (occ > 0));
            end
            if (prevStall) begin
                checks++;
                if (validOut !== 1'b1 || dataOut !== prevData || extOut !== prevExt) begin
                    errors++;
                    $display("[TB] FAIL stall_stable got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             validOut, dataOut, extOut, prevData, prevExt);
                end
            end
            if (validOut && readyOut) begin
                checks++;
                if (scoreQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output got d=%h e=%b want none", dataOut, extOut);
                end else begin
                    logic [9:0] exp;
                    exp = scoreQ.pop_front();
                    if ({extOut, dataOut} !== exp) begin
                        errors++;
                        $display("[TB] FAIL scoreboard got d=%h e=%b want d=%h e=%b",
                                 dataOut, extOut, exp[7:0], exp[9:8]);
                    end
                end
                outCount++;
                occ--;
            end
            if (validIn && readyIn) begin
                scoreQ.push_back(curExp);
                occ++;
            end
            prevStall = validOut && !readyOut;
            prevData  = dataOut;
            prevExt   = extOut;
        end
    end

    task automatic driveWord(input logic [9:0] d, input logic [9:0] exp);
        dataIn  = d;
        curExp  = exp;
        validIn = 1'b1;
    endtask

    task automatic waitAccept();
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (readyIn) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got no ready_in want accept within 200 cycles");
        end
    endtask

    task automatic sendWord(input logic [7:0] p, input logic [1:0] f);
        driveWord(ins3(p, f), {f, p});
        waitAccept();
    endtask

    task automatic waitDrain();
        bit done = 0;
        readyOut = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #1;
            if (scoreQ.size() == 0 && validOut === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout got %0d pending want 0", scoreQ.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        validIn = 1'b0; dataIn = '0; readyOut = 1'b1; curExp = '0;
        validIn2 = 1'b0; dataIn2 = '0; readyOut2 = 1'b1;
        validInS = 1'b0; dataInS = '0;
        #2;
        checks++;
        if (validOut !== 1'b0 || readyIn !== 1'b1 || dataOut !== 8'h00 || extOut !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b r=%b d=%h e=%b want v=0 r=1 d=00 e=00",
                     validOut, readyIn, dataOut, extOut);
        end
        checks++;
        if (validOut0 !== 1'b0 || validOut8 !== 1'b0 || validOutS !== 1'b0 || extOutS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_variants got v0=%b v8=%b vs=%b es=%b want 0 0 0 0",
                     validOut0, validOut8, validOutS, extOutS);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        readyOut = 1'b1;
        driveWord(10'h2CD, {2'b01, 8'hB5});
        @(posedge clk);
        #1;
        validIn = 1'b0;
        checks++;
        if (validOut !== 1'b1 || dataOut !== 8'hB5 || extOut !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_pos3 got v=%b d=%h e=%b want v=1 d=b5 e=01",
                     validOut, dataOut, extOut);
        end
        @(posedge clk);
        #1;
        checks++;
        if (validOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_empty got v=%b want v=0", validOut);
        end
    endtask

    task automatic test_pos_variants();
        validIn2 = 1'b1; dataIn2 = 10'h2CD;
        validInS = 1'b1; dataInS = 8'hA7;
        @(posedge clk);
        #1;
        validIn2 = 1'b0; validInS = 1'b0;
        checks++;
        if (validOut0 !== 1'b1 || dataOut0 !== 8'hB3 || extOut0 !== 2'b01) begin
            errors++;
            $display("[TB] FAIL pos0 got v=%b d=%h e=%b want v=1 d=b3 e=01", validOut0, dataOut0, extOut0);
        end
        checks++;
        if (validOut8 !== 1'b1 || dataOut8 !== 8'hCD || extOut8 !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pos8 got v=%b d=%h e=%b want v=1 d=cd e=10", validOut8, dataOut8, extOut8);
        end
        checks++;
        if (validOutS !== 1'b1 || dataOutS !== 8'hA7 || extOutS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL s0_pass got v=%b d=%h e=%b want v=1 d=a7 e=0", validOutS, dataOutS, extOutS);
        end
        @(posedge clk);
        #1;
        checks++;
        if (validOut0 !== 1'b0 || validOut8 !== 1'b0 || validOutS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL variants_empty got %b%b%b want 000", validOut0, validOut8, validOutS);
        end
    endtask

    task automatic test_back_to_back();
        int startCount;
        readyOut = 1'b1;
        startCount = outCount;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (readyIn !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_ready word=%0d got=%b want=1", i, readyIn);
            end
            sendWord(8'(i), 2'(i % 4));
        end
        validIn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outCount - startCount != 16 || scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL stream_count got %0d out %0d pending want 16 out 0 pending",
                     outCount - startCount, scoreQ.size());
        end
    endtask

    task automatic test_stall();
        readyOut = 1'b0;
        sendWord(8'h11, 2'b01);
        sendWord(8'h22, 2'b10);
        driveWord(ins3(8'h33, 2'b11), {2'b11, 8'h33});
        checks++;
        if (readyIn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_full_ready got=%b want=0", readyIn);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (readyIn !== 1'b0 || validOut !== 1'b1 || dataOut !== 8'h11 || extOut !== 2'b01) begin
                errors++;
                $display("[TB] FAIL stall_hold got r=%b v=%b d=%h e=%b want r=0 v=1 d=11 e=01",
                         readyIn, validOut, dataOut, extOut);
            end
        end
        readyOut = 1'b1;
        waitAccept();
        validIn = 1'b0;
        waitDrain();
    endtask

    task automatic test_random();
        randDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        validIn = 1'b0;
                        dataIn = 10'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    sendWord(8'($urandom), 2'($urandom));
                end
                validIn = 1'b0;
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    readyOut = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        waitDrain();
    endtask

    task automatic test_reset_full();
        readyOut = 1'b0;
        sendWord(8'h5A, 2'b10);
        sendWord(8'hA5, 2'b01);
        validIn = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (validOut !== 1'b0 || dataOut !== 8'h00 || extOut !== 2'b00 || readyIn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_full got v=%b d=%h e=%b r=%b want v=0 d=00 e=00 r=1",
                     validOut, dataOut, extOut, readyIn);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        readyOut = 1'b1;
        sendWord(8'hC3, 2'b11);
        validIn = 1'b0;
        checks++;
        if (validOut !== 1'b1 || dataOut !== 8'hC3 || extOut !== 2'b11) begin
            errors++;
            $display("[TB] FAIL after_reset got v=%b d=%h e=%b want v=1 d=c3 e=11", validOut, dataOut, extOut);
        end
        waitDrain();
        validInS = 1'b1; dataInS = 8'h3C;
        @(posedge clk);
        #1;
        validInS = 1'b0;
        checks++;
        if (validOutS !== 1'b1 || dataOutS !== 8'h3C || extOutS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL s0_after_reset got v=%b d=%h e=%b want v=1 d=3c e=0",
                     validOutS, dataOutS, extOutS);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pos_variants();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
